// File: rtl/time_setter_pkg.sv
// Shared types and constants for the time-entry stage: edit states,
// field limits and the wrap-around step used by the hour/minute/second editors.
package time_setter_pkg;

    localparam int FIELD_W = 8;

    localparam logic [FIELD_W-1:0] HOUR_MAX    = 8'd23;
    localparam logic [FIELD_W-1:0] MIN_SEC_MAX = 8'd59;

    // Encoding doubles as the field_sel output seen by the display stage.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    function automatic logic [FIELD_W-1:0] step_field(
        input logic [FIELD_W-1:0] value,
        input logic [FIELD_W-1:0] max,
        input logic               up,
        input logic               down
    );
        logic [FIELD_W-1:0] result;
        result = value;
        if (up && !down) begin
            result = (value >= max) ? '0 : value + 8'd1;
        end else if (down && !up) begin
            result = (value == '0) ? max : value - 8'd1;
        end
        return result;
    endfunction

    function automatic logic [FIELD_W-1:0] sanitize(
        input logic [FIELD_W-1:0] value,
        input logic [FIELD_W-1:0] max
    );
        return (value > max) ? '0 : value;
    endfunction

endpackage

// File: rtl/time_setter_btn_debounce.sv
// One push-button path: 2-flop synchronizer, debounce counter, accepted
// level and a single-cycle press pulse on its rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [CW-1:0] cnt;

    // The counter only runs while the synced level disagrees with the accepted one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/time_setter.sv
// Time-entry stage: debounced mode/inc/dec buttons drive an edit FSM over
// hour/minute/second and hand the result to the counter with a load strobe.
// Optional auto-repeat on held inc/dec is enabled by TIME_SETTER_AUTO_REPEAT_EN.
module time_setter
    import time_setter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         btn_mode,
    input  logic         btn_inc,
    input  logic         btn_dec,
    input  logic [7:0]   hour_in,
    input  logic [7:0]   minute_in,
    input  logic [7:0]   second_in,
    output logic [7:0]   set_hour,
    output logic [7:0]   set_minute,
    output logic [7:0]   set_second,
    output logic         load,
    output logic         edit_active,
    output logic [1:0]   field_sel
);

    state_t state;
    logic   mode_level, inc_level, dec_level;
    logic   mode_press, inc_press, dec_press;
    logic   inc_step, dec_step;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .resetn(resetn), .btn_raw(btn_mode), .level(mode_level), .press(mode_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .resetn(resetn), .btn_raw(btn_inc), .level(inc_level), .press(inc_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk(clk), .resetn(resetn), .btn_raw(btn_dec), .level(dec_level), .press(dec_press)
    );

`ifdef TIME_SETTER_AUTO_REPEAT_EN
    logic [31:0] rep_cnt [2];
    logic [1:0]  rep_fast;
    logic [1:0]  rep_fire;
    logic [1:0]  held;
    logic [1:0]  pressed;
    logic        unused_levels;

    assign held          = {dec_level, inc_level};
    assign pressed       = {dec_press, inc_press};
    assign unused_levels = mode_level;

    // First repeat waits REPEAT_DELAY after the press, later ones REPEAT_PERIOD.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < 2; i++) begin
            rep_fire[i] = held[i] && (state != RUN) && (rep_cnt[i] != 32'd0) &&
                          (rep_cnt[i] == (rep_fast[i] ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY)));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rep_cnt[0] <= '0;
            rep_cnt[1] <= '0;
            rep_fast   <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!held[i] || state == RUN || mode_press) begin
                    rep_cnt[i]  <= '0;
                    rep_fast[i] <= 1'b0;
                end else if (pressed[i]) begin
                    rep_cnt[i]  <= 32'd1;
                    rep_fast[i] <= 1'b0;
                end else if (rep_fire[i]) begin
                    rep_cnt[i]  <= 32'd1;
                    rep_fast[i] <= 1'b1;
                end else if (rep_cnt[i] != 32'd0) begin
                    rep_cnt[i] <= rep_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign inc_step = inc_press | rep_fire[0];
    assign dec_step = dec_press | rep_fire[1];
`else
    localparam int unused_repeat = REPEAT_DELAY + REPEAT_PERIOD;
    logic          unused_levels;

    assign unused_levels = mode_level ^ inc_level ^ dec_level;
    assign inc_step      = inc_press;
    assign dec_step      = dec_press;
`endif

    // Mode presses take priority; inc/dec only act on the field of a SET state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= RUN;
            set_hour    <= '0;
            set_minute  <= '0;
            set_second  <= '0;
            load        <= 1'b0;
            edit_active <= 1'b0;
        end else begin
            load <= 1'b0;
            if (mode_press) begin
                case (state)
                    RUN: begin
                        state       <= SET_H;
                        edit_active <= 1'b1;
                        set_hour    <= sanitize(hour_in, HOUR_MAX);
                        set_minute  <= sanitize(minute_in, MIN_SEC_MAX);
                        set_second  <= sanitize(second_in, MIN_SEC_MAX);
                    end
                    SET_H: state <= SET_M;
                    SET_M: state <= SET_S;
                    SET_S: begin
                        state       <= RUN;
                        edit_active <= 1'b0;
                        load        <= 1'b1;
                    end
                    default: state <= RUN;
                endcase
            end else begin
                case (state)
                    SET_H:   set_hour   <= step_field(set_hour, HOUR_MAX, inc_step, dec_step);
                    SET_M:   set_minute <= step_field(set_minute, MIN_SEC_MAX, inc_step, dec_step);
                    SET_S:   set_second <= step_field(set_second, MIN_SEC_MAX, inc_step, dec_step);
                    default: ;
                endcase
            end
        end
    end

    assign field_sel = state;

endmodule

// File: doc/time_setter.md
# time_setter

User time-entry stage directly upstream of the time-keeping counter. Debounces three raw push-buttons, runs an edit-mode state machine over the hour, minute and second fields, and hands a complete new time to the counter with a single-cycle load strobe. While editing, it also exposes the in-progress values so the LCD text stage can display them instead of the running time.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 50000: stable-input cycles required before a button level is accepted (≥2).
- REPEAT_DELAY, default 25000000: hold cycles before auto-repeat starts. Used only with the configuration macro.
- REPEAT_PERIOD, default 5000000: cycles between auto-repeat steps. Used only with the configuration macro.

Ports:
- clk  in  1  system clock. One clock domain.
- resetn  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw mode button, active high, asynchronous to clk.
- btn_inc  in  1  raw increment button, active high, asynchronous.
- btn_dec  in  1  raw decrement button, active high, asynchronous.
- hour_in  in  8  current hour from the counter, binary.
- minute_in  in  8  current minute from the counter, binary.
- second_in  in  8  current second from the counter, binary.
- set_hour  out  8  edit hour, binary, 0..23.
- set_minute  out  8  edit minute, binary, 0..59.
- set_second  out  8  edit second, binary, 0..59.
- load  out  1  one-cycle strobe: counter takes set_* this edge.
- edit_active  out  1  high in every state except RUN.
- field_sel  out  2  current state encoding (0 RUN, 1 SET_H, 2 SET_M, 3 SET_S), used for display blinking.

## Operation
- Each button path: 2-flop synchronizer, then debounce. A counter clears whenever the synced level differs from the accepted level. When the counter reaches DEBOUNCE_CYCLES-1, the accepted level takes the synced value. A press event is a one-cycle rising edge of the accepted level. Releases generate no event.
- State machine, advanced by mode presses:
  - RUN -> SET_H: capture hour_in/minute_in/second_in into the edit registers. Any captured value out of range (hour >23, minute or second >59) is replaced by 0.
  - SET_H -> SET_M -> SET_S.
  - SET_S -> RUN: pulse load for exactly one cycle on the transition edge.
- inc/dec presses modify the field selected by the state, with wrap-around:
  - hour: 23 +1 -> 0; 0 -1 -> 23.
  - minute and second: 59 +1 -> 0; 0 -1 -> 59.
- inc/dec presses are ignored in RUN.
- Simultaneous events:
  - inc and dec in the same cycle: no change.
  - mode together with inc or dec: mode is applied, inc/dec dropped.
- set_* are driven by the edit registers at all times. They only take effect in the counter when load is high.
- Reset mid-edit: returns to RUN with no load pulse, and the edit being made is discarded.
- Reset values of outputs:
  - set_hour, set_minute, set_second = 0.
  - load = 0, edit_active = 0, field_sel = 0.
- Reset values of internal state: accepted levels = 0, all counters = 0.

## Timing
- Raw level change held stable -> accepted level changes DEBOUNCE_CYCLES+2 cycles later.
- State or field register updates on the following edge. Total latency is DEBOUNCE_CYCLES+3 cycles.
- Glitches shorter than DEBOUNCE_CYCLES synced cycles produce no event.
- Timing of load:
  - load is registered, high for one cycle, coincident with field_sel returning to 0.
  - set_* are stable from the cycle before load through at least one cycle after it.
- No backpressure: the counter must accept load in the cycle it is asserted.

## Configuration
- TIME_SETTER_AUTO_REPEAT_EN defined:
  - While the accepted inc or dec level stays high in a SET state for REPEAT_DELAY cycles after the press event, an extra step event is generated.
  - Further step events follow every REPEAT_PERIOD cycles until release.
  - A mode press or release clears the repeat counter.
- Undefined: exactly one step per press. The repeat counters and both REPEAT_* parameters have no effect and are not synthesized.

## Structure
- Package time_setter_pkg holds:
  - the state enum (RUN, SET_H, SET_M, SET_S, encoded as field_sel);
  - constants HOUR_MAX = 23 and MIN_SEC_MAX = 59;
  - the field width of 8.
- Sub-module btn_debounce: synchronizer, debounce counter, accepted level and press-edge output. Parameterized by DEBOUNCE_CYCLES. Instantiated three times.
- Field arithmetic, FSM and the repeat logic stay in time_setter.

## Test plan
Every scenario uses DEBOUNCE_CYCLES = 4.
- Mode press with hour_in=12, minute_in=34, second_in=56 -> field_sel=1, edit_active=1, set_*=12/34/56; no load.
- In SET_H with hour=23, inc press -> set_hour=0. In SET_M with minute=0, dec press -> set_minute=59.
- Three mode presses from RUN with one inc in SET_S, second=56 -> exactly one load cycle, set_second=57, field_sel=0 in the same cycle.
- Button bounce: 3-cycle pulses toggling for 20 cycles, then a steady high -> exactly one press event, registered DEBOUNCE_CYCLES+3 cycles after the steady level.
- inc and dec pressed together -> field unchanged. Mode and inc together in SET_H -> state SET_M, hour unchanged.
- resetn low while in SET_M -> all outputs 0 immediately and no load pulse. With the macro on, REPEAT_DELAY=10 and REPEAT_PERIOD=5, holding inc for 30 cycles after the press -> 1 + 1 + 3 = 5 steps.
